// File: rtl/textcon_seq.sv
// textcon_seq: byte-stream console sequencer driving the character-write port of a 32x28 text display.
module textcon_seq #(
    parameter int         COLS  = 32,
    parameter int         ROWS  = 28,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        char_we,
    output logic [31:0] char_di,
    output logic [4:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy
);
    localparam logic [4:0] XMAX = 5'(COLS - 1);
    localparam logic [4:0] YMAX = 5'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, PUT, CLR_LINE, CLR_ALL} state_t;

    state_t     r_state;
    logic       r_wrap;
    logic [4:0] r_sx;
    logic [4:0] r_sy;

    logic       w_take;
    logic       w_print;
    logic [4:0] w_ny;

    assign w_take  = in_valid && in_ready;
    assign w_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign w_ny    = (cur_y == YMAX) ? 5'd0 : cur_y + 5'd1;

    function automatic logic [31:0] word(input logic [4:0] x, input logic [4:0] y, input logic [7:0] c);
        return {8'h00, 3'b000, x, 3'b000, y, 1'b0, c[6:0]};
    endfunction

    // Leaving a clear jumps straight to IDLE on the last write so in_ready rises the cycle after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= CLR_ALL;
            r_wrap   <= 1'b0;
            r_sx     <= 5'd0;
            r_sy     <= 5'd0;
            char_we  <= 1'b0;
            char_di  <= 32'd0;
            in_ready <= 1'b0;
            cur_x    <= 5'd0;
            cur_y    <= 5'd0;
            busy     <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    char_we  <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= !w_take;
                    if (w_take) begin
                        if (w_print) begin
                            char_we <= 1'b1;
                            char_di <= word(cur_x, cur_y, in_data);
                            r_wrap  <= (cur_x == XMAX);
                            r_state <= PUT;
                            cur_x   <= (cur_x == XMAX) ? 5'd0 : cur_x + 5'd1;
                            if (cur_x == XMAX) cur_y <= w_ny;
                        end else if (in_data == 8'h0A) begin
                            cur_x   <= 5'd0;
                            cur_y   <= w_ny;
                            r_sx    <= 5'd0;
                            busy    <= 1'b1;
                            r_state <= CLR_LINE;
                        end else if (in_data == 8'h0D) begin
                            cur_x <= 5'd0;
                        end else if (in_data == 8'h08 && cur_x != 5'd0) begin
                            cur_x   <= cur_x - 5'd1;
                            char_we <= 1'b1;
                            char_di <= word(cur_x - 5'd1, cur_y, BLANK);
                            r_wrap  <= 1'b0;
                            r_state <= PUT;
                        end else if (in_data == 8'h0C) begin
                            cur_x   <= 5'd0;
                            cur_y   <= 5'd0;
                            r_sx    <= 5'd0;
                            r_sy    <= 5'd0;
                            busy    <= 1'b1;
                            r_state <= CLR_ALL;
                        end
                    end
                end
                PUT: begin
                    char_we <= 1'b0;
                    if (r_wrap) begin
                        r_sx    <= 5'd0;
                        busy    <= 1'b1;
                        r_state <= CLR_LINE;
                    end else begin
                        in_ready <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                CLR_LINE: begin
                    char_we <= 1'b1;
                    char_di <= word(r_sx, cur_y, BLANK);
                    r_sx    <= r_sx + 5'd1;
                    if (r_sx == XMAX) r_state <= IDLE;
                end
                CLR_ALL: begin
                    char_we <= 1'b1;
                    char_di <= word(r_sx, r_sy, BLANK);
                    r_sx    <= (r_sx == XMAX) ? 5'd0 : r_sx + 5'd1;
                    if (r_sx == XMAX) r_sy <= (r_sy == YMAX) ? 5'd0 : r_sy + 5'd1;
                    if (r_sx == XMAX && r_sy == YMAX) r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_textcon_seq.sv
// tb_textcon_seq: vector table, hand sequences and randomized bytes checked against a screen-rule model.
module tb_textcon_seq;
    localparam int COLS = 32;
    localparam int ROWS = 28;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        char_we;
    logic [31:0] char_di;
    logic [4:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    int errs = 0;
    int checks = 0;
    int mx = 0;
    int my = 0;
    logic [31:0] wq[$];
    logic [31:0] eq[$];

    typedef struct {
        logic [7:0]  b;
        int          ex;
        int          ey;
        int          nw;
        logic [31:0] w0;
    } vec_t;

    textcon_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .char_we(char_we), .char_di(char_di), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (char_we) wq.push_back(char_di);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] w(input int x, input int y, input logic [7:0] c);
        return {8'h00, 8'(x), 8'(y), 1'b0, c[6:0]};
    endfunction

    function automatic void newline();
        my = (my + 1) % ROWS;
        for (int x = 0; x < COLS; x++) eq.push_back(w(x, my, 8'h20));
    endfunction

    function automatic void model(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            eq.push_back(w(mx, my, b));
            if (mx == COLS - 1) begin
                mx = 0;
                newline();
            end else mx++;
        end else if (b == 8'h0A) begin
            mx = 0;
            newline();
        end else if (b == 8'h0D) mx = 0;
        else if (b == 8'h08) begin
            if (mx > 0) begin
                mx--;
                eq.push_back(w(mx, my, 8'h20));
            end
        end else if (b == 8'h0C) begin
            mx = 0;
            my = 0;
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++) eq.push_back(w(x, y, 8'h20));
        end
    endfunction

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("idle_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send_chk(input logic [7:0] b);
        int bad = 0;
        eq.delete();
        wq.delete();
        model(b);
        send(b);
        wait_idle();
        chk("writes_n", 32'(wq.size()), 32'(eq.size()));
        for (int i = 0; i < wq.size() && i < eq.size(); i++) if (wq[i] !== eq[i]) bad++;
        chk("writes_data", 32'(bad), 32'd0);
        chk("cur_x", {27'd0, cur_x}, 32'(mx));
        chk("cur_y", {27'd0, cur_y}, 32'(my));
    endtask

    task automatic clr_all(input string nm);
        int n = 0;
        int cyc = 0;
        int bad = 0;
        logic [31:0] first = 0;
        logic [31:0] last = 0;
        while (!in_ready && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (char_we) begin
                if (n == 0) first = char_di;
                last = char_di;
                n++;
                if (!busy || char_di[7:0] != 8'h20) bad++;
            end
        end
        chk({nm, "_count"}, 32'(n), 32'd896);
        chk({nm, "_first"}, first, 32'h0000_0020);
        chk({nm, "_last"}, last, 32'h001F_1B20);
        chk({nm, "_bad_writes"}, 32'(bad), 32'd0);
        chk({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_cur"}, {22'd0, cur_x, 5'd0, cur_y}, 32'd0);
    endtask

    initial begin
        vec_t vt[12];
        int n;
        int cyc;
        logic [7:0] b;
        vt[0]  = '{8'h43, 3, 0, 1,   32'h0002_0043};
        vt[1]  = '{8'h08, 2, 0, 1,   32'h0002_0020};
        vt[2]  = '{8'h0D, 0, 0, 0,   32'h0};
        vt[3]  = '{8'h08, 0, 0, 0,   32'h0};
        vt[4]  = '{8'h80, 0, 0, 0,   32'h0};
        vt[5]  = '{8'h0A, 0, 1, 32,  32'h0000_0120};
        vt[6]  = '{8'h7E, 1, 1, 1,   32'h0000_017E};
        vt[7]  = '{8'h1F, 1, 1, 0,   32'h0};
        vt[8]  = '{8'h7F, 1, 1, 0,   32'h0};
        vt[9]  = '{8'hC1, 1, 1, 0,   32'h0};
        vt[10] = '{8'h20, 2, 1, 1,   32'h0001_0120};
        vt[11] = '{8'h0C, 0, 0, 896, 32'h0000_0020};

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_we", {31'd0, char_we}, 32'd0);
        chk("rst_di", char_di, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_cur", {22'd0, cur_x, 5'd0, cur_y}, 32'd0);
        reset = 1'b0;
        clr_all("por");

        // Back-to-back bytes with in_valid held high across both transfers.
        in_valid = 1'b1;
        in_data = 8'h41;
        @(negedge clk);
        chk("ab_we1", {31'd0, char_we}, 32'd1);
        chk("ab_di1", char_di, 32'h0000_0041);
        chk("ab_ready1", {31'd0, in_ready}, 32'd0);
        in_data = 8'h42;
        @(negedge clk);
        chk("ab_gap_ready", {31'd0, in_ready}, 32'd1);
        chk("ab_gap_we", {31'd0, char_we}, 32'd0);
        @(negedge clk);
        chk("ab_we2", {31'd0, char_we}, 32'd1);
        chk("ab_di2", char_di, 32'h0001_0042);
        chk("ab_ready2", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wait_idle();
        chk("ab_cur", {22'd0, cur_x, 5'd0, cur_y}, {22'd0, 5'd2, 5'd0, 5'd0});

        for (int i = 0; i < 12; i++) begin
            wq.delete();
            send(vt[i].b);
            wait_idle();
            chk($sformatf("vec%0d_nw", i), 32'(wq.size()), 32'(vt[i].nw));
            if (vt[i].nw > 0 && wq.size() > 0) chk($sformatf("vec%0d_w0", i), wq[0], vt[i].w0);
            chk($sformatf("vec%0d_x", i), {27'd0, cur_x}, 32'(vt[i].ex));
            chk($sformatf("vec%0d_y", i), {27'd0, cur_y}, 32'(vt[i].ey));
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
        end

        mx = 0;
        my = 0;
        repeat (5) send_chk(8'h0A);
        repeat (31) send_chk(8'h78);
        send_chk(8'h5A);
        chk("wrap_size", 32'(wq.size()), 32'd33);
        if (wq.size() == 33) begin
            chk("wrap_put", wq[0], 32'h001F_055A);
            chk("wrap_first_blank", wq[1], 32'h0000_0620);
            chk("wrap_last_blank", wq[32], 32'h001F_0620);
        end
        chk("wrap_cur", {22'd0, cur_x, 5'd0, cur_y}, {22'd0, 5'd0, 5'd0, 5'd6});

        repeat (21) send_chk(8'h0A);
        repeat (7) send_chk(8'h2E);
        send_chk(8'h0A);
        chk("bot_size", 32'(wq.size()), 32'd32);
        if (wq.size() == 32) begin
            chk("bot_first", wq[0], 32'h0000_0020);
            chk("bot_last", wq[31], 32'h001F_0020);
        end
        chk("bot_cur", {22'd0, cur_x, 5'd0, cur_y}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            n = int'($urandom_range(0, 99));
            if (n < 60) b = 8'($urandom_range(32, 126));
            else if (n < 68) b = 8'h0A;
            else if (n < 74) b = 8'h0D;
            else if (n < 84) b = 8'h08;
            else if (n < 85) b = 8'h0C;
            else b = 8'($urandom);
            send_chk(b);
        end

        send(8'h0A);
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (char_we) n++;
        end
        chk("mid_writes", 32'(n), 32'd10);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", {31'd0, char_we}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd1);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_cur", {22'd0, cur_x, 5'd0, cur_y}, 32'd0);
        reset = 1'b0;
        clr_all("mid");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/textcon_seq.md
Name: textcon_seq

Overview:
- Console sequencer that drives the character-write port of the 32x28 text display.
- Accepts a byte stream over a valid/ready handshake and tracks a cursor.
- Converts printable bytes and control codes into one-per-cycle character writes in the display's register format.
- Performs line wrap, row clearing on newline, and full-screen clear, so the CPU only pushes bytes.

Parameters:
- COLS, 32, text columns; the cursor X range is 0..COLS-1.
- ROWS, 28, text rows; the cursor Y range is 0..ROWS-1.
- BLANK, 8'h20, character written when clearing cells.

Ports:
- clk  input  1  main logic clock; all logic is in this domain.
- reset  input  1  synchronous reset, active-high.
- in_valid  input  1  byte available.
- in_data  input  8  byte to print or control code.
- in_ready  output  1  block can accept a byte this cycle.
- char_we  output  1  one-cycle write strobe; drives bit 0 of the display write-enable.
- char_di  output  32  write word: [31:24]=8'h00 (cmd 0), [23:16]={3'b0,x}, [15:8]={3'b0,y}, [7:0]={1'b0,char[6:0]}.
- cur_x  output  5  current cursor column.
- cur_y  output  5  current cursor row.
- busy  output  1  high while a clear sequence is in progress.

Behaviour:
- All outputs are registered.
- Reset values: char_we=0, char_di=0, in_ready=0, cur_x=0, cur_y=0, busy=1. The state after reset is CLR_ALL.
- States:
  - IDLE: in_ready=1. A transfer occurs on a cycle where in_valid&&in_ready; in_ready drops the next cycle.
  - PUT: char_we=1 for exactly one cycle, then go to IDLE or CLR_LINE.
  - CLR_LINE: 32 consecutive write cycles of BLANK to row cur_y, columns 0..31 ascending, then IDLE.
  - CLR_ALL: 896 consecutive writes of BLANK, row-major from (0,0) to (31,27), then IDLE with cursor at (0,0).
- Write latency: a byte accepted in cycle N produces its char_we pulse in cycle N+1. in_ready returns high in N+2 at the earliest, giving a max throughput of 1 byte per 2 cycles.
- Decode of an accepted byte:
  - 0x20..0x7E: write at (cur_x,cur_y).
    - If cur_x<31, then cur_x+1 and return to IDLE.
    - If cur_x==31, then cur_x=0, newline, and go to CLR_LINE.
  - 0x0A LF: cur_x=0, newline, then CLR_LINE. No PUT write.
  - 0x0D CR: cur_x=0 and stay in IDLE. No write.
  - 0x08 BS:
    - If cur_x>0, then cur_x-1 and write BLANK at the new position (PUT).
    - If cur_x==0, no cursor change and no write.
  - 0x0C FF: enter CLR_ALL; the cursor resets to (0,0) at entry.
  - Any other byte (including bit7=1): consumed, no write, no cursor change.
- Newline: cur_y = (cur_y==27) ? 0 : cur_y+1. There is no scrolling; the target row is cleared instead.
- Cursor outputs update in the same cycle as the PUT write, or at CLR entry. During CLR_LINE, cur_x/cur_y show the final cursor, not the sweep position.
- Clear sweep positions use internal counters; the x counter wraps 31->0 and increments y.
- busy=1 in CLR_LINE and CLR_ALL, 0 otherwise. in_ready=0 whenever not in IDLE.
- Bytes presented while in_ready=0 are not consumed; the producer must hold in_valid and in_data.
- Reset mid-operation: any state aborts immediately. char_we=0 in the reset cycle, and CLR_ALL restarts from (0,0) after reset deasserts.
- char_di holds its last value when char_we=0; consumers ignore it then.

Test Plan:
- Reset then idle: assert reset 2 cycles -> exactly 896 char_we pulses with char_di[7:0]=0x20, first {x=0,y=0}, last {x=31,y=27}, busy=1 throughout. in_ready=1 and busy=0 on the next cycle; cur=(0,0).
- Print "AB" at (0,0): send 0x41, 0x42 back-to-back with in_valid held -> char_di=0x00000041 then 0x00010042, each one cycle after acceptance, in_ready low between. cur=(2,0).
- Line wrap: cursor at (31,5), send 0x5A -> write 0x001F055A, then 32 BLANK writes to row 6, x 0..31. cur=(0,6).
- Bottom wrap via LF at (7,27) -> no char write, 32 BLANK writes to row 0. cur=(0,0).
- Control codes: at (3,2) send BS -> write 0x00020220, cur=(2,2); BS at (0,4) -> no write, cur unchanged; CR at (9,1) -> cur=(0,1), no write; byte 0x80 -> consumed, nothing written.
- Reset during CLR_LINE after 10 writes: reset 1 cycle -> char_we=0 in the reset cycle, then a full 896-write CLR_ALL from (0,0). cur=(0,0).
